// File: rtl/fb_write_ctrl_pkg.sv
// Shared sizes and FSM encodings for the framebuffer write controller.
package fb_write_ctrl_pkg;

    localparam int FB_ADDR_W = 14;
    localparam int FB_DATA_W = 20;
    localparam int FB_NPIX   = 16384;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } fb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fb_write_ctrl.sv
// Write side of the double-buffered framebuffer: fills the back bank with one frame,
// then flips the bank select only on a display frame boundary.
module fb_write_ctrl
    import fb_write_ctrl_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int NPIX   = FB_NPIX
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              disp_frame_start,
    output logic [DATA_W-1:0] fb_wdata,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic              fb_we,
    output logic              fb_sel,
    output logic              swap_pending,
    output logic [15:0]       frames_swapped,
    output logic [7:0]        resync_count
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_q, sel_d;
    logic              swap_q, swap_d;
    logic [15:0]       frames_q, frames_d;
    logic [7:0]        resync_q, resync_d;
    logic              acc;

    assign acc = in_valid && rdy_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        swap_d   = swap_q;
        frames_d = frames_q;
        resync_d = resync_q;
        case (state_q)
            ST_HUNT: begin
                if (acc && in_sof) begin
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = in_data;
                    cnt_d   = ADDR_W'(1);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (acc) begin
                    we_d    = 1'b1;
                    wdata_d = in_data;
                    if (in_sof && cnt_q != '0) begin
                        waddr_d  = '0;
                        cnt_d    = ADDR_W'(1);
                        resync_d = sat_inc8(resync_q);
                    end else begin
                        waddr_d = cnt_q;
                        if (cnt_q == LAST_PIX) begin
                            cnt_d   = '0;
                            swap_d  = 1'b1;
                            state_d = ST_WAIT_SWAP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_SWAP: begin
                // A pulse coinciding with the last beat is seen while still in WRITE,
                // so the flip always follows the final write.
                if (disp_frame_start) begin
                    sel_d    = ~sel_q;
                    swap_d   = 1'b0;
                    frames_d = frames_q + 16'd1;
                    state_d  = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
        rdy_d = (state_d != ST_WAIT_SWAP);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            sel_q    <= 1'b0;
            swap_q   <= 1'b0;
            frames_q <= '0;
            resync_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            swap_q   <= swap_d;
            frames_q <= frames_d;
            resync_q <= resync_d;
        end
    end

    assign in_ready       = rdy_q;
    assign fb_we          = we_q;
    assign fb_waddr       = waddr_q;
    assign fb_wdata       = wdata_q;
    assign fb_sel         = sel_q;
    assign swap_pending   = swap_q;
    assign frames_swapped = frames_q;
    assign resync_count   = resync_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl with a write scoreboard (NPIX=16).
module tb_fb_write_ctrl;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 20;
    localparam int NPIX   = 16;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              sys_clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_sof = 1'b0;
    logic              disp_frame_start = 1'b0;
    logic [DATA_W-1:0] fb_wdata;
    logic [ADDR_W-1:0] fb_waddr;
    logic              fb_we;
    logic              fb_sel;
    logic              swap_pending;
    logic [15:0]       frames_swapped;
    logic [7:0]        resync_count;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];

    fb_write_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPIX(NPIX)) dut (
        .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .disp_frame_start(disp_frame_start),
        .fb_wdata(fb_wdata), .fb_waddr(fb_waddr), .fb_we(fb_we), .fb_sel(fb_sel),
        .swap_pending(swap_pending), .frames_swapped(frames_swapped),
        .resync_count(resync_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge sys_clk);
            if (fb_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(fb_waddr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(fb_waddr), 32'(e.a));
                    check("write_data", 32'(fb_wdata), 32'(e.d));
                end
            end
        end
    end

    // One beat; waits (bounded) for in_ready, then holds it for exactly one edge.
    task automatic beat(input logic [DATA_W-1:0] d, input logic sof, input logic pulse,
                        input logic wr, input int addr);
        int n = 0;
        wr_t e;
        @(negedge sys_clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        disp_frame_start = pulse;
        if (wr) begin
            e.a = ADDR_W'(addr);
            e.d = d;
            exp_q.push_back(e);
        end
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        disp_frame_start = 1'b0;
    endtask

    task automatic frame(input int base);
        for (int i = 0; i < NPIX; i++)
            beat(DATA_W'(base + i), (i == 0), 1'b0, 1'b1, i);
    endtask

    task automatic pulse_disp();
        @(negedge sys_clk);
        disp_frame_start = 1'b1;
        @(posedge sys_clk);
        #1;
        disp_frame_start = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, 32'(fb_we), 0);
        check({tag, "_waddr"}, 32'(fb_waddr), 0);
        check({tag, "_wdata"}, 32'(fb_wdata), 0);
        check({tag, "_sel"}, 32'(fb_sel), 0);
        check({tag, "_swap"}, 32'(swap_pending), 0);
        check({tag, "_frames"}, 32'(frames_swapped), 0);
        check({tag, "_resync"}, 32'(resync_count), 0);
        check({tag, "_ready"}, 32'(in_ready), 0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Full frame, then swap 5 cycles after the last beat.
        frame(0);
        @(negedge sys_clk);
        check("f1_swap_pending", 32'(swap_pending), 1);
        check("f1_ready_low", 32'(in_ready), 0);
        repeat (3) @(negedge sys_clk);
        check("f1_sel_held", 32'(fb_sel), 0);
        pulse_disp();
        check("f1_sel", 32'(fb_sel), 1);
        check("f1_frames", 32'(frames_swapped), 1);
        check("f1_swap_clr", 32'(swap_pending), 0);
        check("f1_ready", 32'(in_ready), 1);

        // Leading non-SOF beats are dropped.
        for (int i = 0; i < 3; i++) beat(DATA_W'(50 + i), 1'b0, 1'b0, 1'b0, 0);
        frame(100);
        @(negedge sys_clk);
        check("f2_swap_pending", 32'(swap_pending), 1);
        pulse_disp();
        check("f2_sel", 32'(fb_sel), 0);
        check("f2_frames", 32'(frames_swapped), 2);

        // Early SOF after 7 beats restarts at address 0.
        for (int i = 0; i < 7; i++) beat(DATA_W'(200 + i), (i == 0), 1'b0, 1'b1, i);
        beat(DATA_W'(300), 1'b1, 1'b0, 1'b1, 0);
        @(negedge sys_clk);
        check("f3_resync", 32'(resync_count), 1);
        check("f3_swap_early", 32'(swap_pending), 0);
        for (int i = 1; i < NPIX; i++) beat(DATA_W'(300 + i), 1'b0, 1'b0, 1'b1, i);
        @(negedge sys_clk);
        check("f3_swap_pending", 32'(swap_pending), 1);
        pulse_disp();
        check("f3_sel", 32'(fb_sel), 1);
        check("f3_frames", 32'(frames_swapped), 3);

        // Display pulse on the same cycle as the last beat must not swap.
        for (int i = 0; i < NPIX; i++)
            beat(DATA_W'(400 + i), (i == 0), (i == NPIX - 1), 1'b1, i);
        @(negedge sys_clk);
        check("f4_sel_held", 32'(fb_sel), 1);
        check("f4_swap_pending", 32'(swap_pending), 1);
        repeat (3) @(negedge sys_clk);
        check("f4_sel_still", 32'(fb_sel), 1);
        check("f4_frames_held", 32'(frames_swapped), 3);
        pulse_disp();
        check("f4_sel", 32'(fb_sel), 0);
        check("f4_frames", 32'(frames_swapped), 4);

        // Get to fb_sel=1 then reset while waiting on the next swap.
        frame(500);
        pulse_disp();
        check("f5_sel", 32'(fb_sel), 1);
        frame(600);
        @(negedge sys_clk);
        check("f6_swap_pending", 32'(swap_pending), 1);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("post_rst_ready", 32'(in_ready), 1);
        check("post_rst_sel", 32'(fb_sel), 0);
        check("post_rst_we", 32'(fb_we), 0);

        check("pending_writes", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
